addr_unit: RTL and testbench
============================

Name: addr_unit

Overview:
- Address-side datapath that consumes the 4-bit control word {pc_out, pc_inc, ldlo, ldhi} from the addressing-mode sequencer.
- Owns the 16-bit program counter (PC) and the 16-bit effective-address latch (EA), and drives the CPU address bus.
- Performs X/Y index addition on EA, with a page-cross fix-up cycle and zero-page wrap.
- Sits between the addressing sequencer/decoder and the external memory bus.

Parameters:
- RESET_PC, 16'hFFFC, PC value loaded on reset (vector fetch location).

Ports:
- i_clk  in  1  system clock, all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_ctrl  in  4  {pc_out, pc_inc, ldlo, ldhi} from the addressing sequencer.
- i_data  in  8  data bus read value, sampled when ldlo/ldhi are set.
- i_pc_load  in  1  load PC from i_pc_val (jumps, vectors).
- i_pc_val  in  16  new PC value.
- i_idx_start  in  1  single-cycle pulse: add i_index_val to EA.
- i_index_val  in  8  X or Y value, already selected by the decoder.
- i_zpg  in  1  sampled with i_idx_start; 1 = zero-page indexed (wrap within page 0).
- o_addr  out  16  address bus: PC when pc_out=1, else EA (combinational mux).
- o_pc  out  16  current PC.
- o_ea  out  16  current EA.
- o_busy  out  1  index operation in progress (ADD or FIX state).
- o_idx_done  out  1  one-cycle pulse when the indexed EA is final.
- o_page_cross  out  1  registered; set when the last index add carried out of the low byte (non-zpg only).

Behaviour:
- Reset (async, immediate on i_rst_n=0):
  - PC=RESET_PC, EA=16'h0000, state=IDLE.
  - o_busy=0, o_idx_done=0, o_page_cross=0.
  - o_addr=16'h0000, since pc_out is driven 0 by the sequencer during reset.
- Reset mid-operation aborts any index add; there is no resumption.
- PC update, every cycle, independent of index state:
  - i_pc_load=1: PC<=i_pc_val. This takes priority over pc_inc.
  - else pc_inc=1: PC<=PC+1, modulo 2^16 (16'hFFFF -> 16'h0000).
- EA byte loads, applied only when state=IDLE and i_idx_start=0:
  - ldlo=1: EA[7:0]<=i_data.
  - ldhi=1: EA[15:8]<=i_data.
  - Both set: both bytes load i_data.
- EA byte loads are ignored while o_busy=1 or on the cycle i_idx_start=1; index arithmetic wins.
- State machine IDLE -> ADD -> (FIX) -> IDLE:
  - IDLE: i_idx_start=1 captures i_index_val and i_zpg, then goes to ADD. i_idx_start is ignored in ADD/FIX; no queuing.
  - ADD:
    - {c,EA[7:0]}<=EA[7:0]+index (9-bit sum).
    - If zpg: EA[15:8]<=8'h00, o_page_cross<=0, go to IDLE and pulse o_idx_done.
    - Else if c=1: o_page_cross<=1, go to FIX.
    - Else: o_page_cross<=0, go to IDLE and pulse o_idx_done.
  - FIX: EA[15:8]<=EA[15:8]+1, modulo 2^8 (16'hFFxx wraps to 16'h00xx). Go to IDLE and pulse o_idx_done.
- o_busy=1 in ADD and FIX.
- o_idx_done is registered and asserted on the cycle after the final EA write, so o_ea is valid when o_idx_done=1.
- Latency from the i_idx_start cycle to o_idx_done: 2 cycles without a fix-up, 3 cycles with one.
- o_page_cross holds until the next ADD.
- o_addr is never registered: no added latency between pc_out and the bus.

Optional Feature:
- ADDR_UNIT_ALWAYS_FIX_EN
- Defined:
  - Non-zpg index adds always pass through FIX. The FIX increment is c (adds 0 when no carry).
  - Fixed 3-cycle latency, matching the store-instruction timing of the original CPU.
  - o_page_cross still reflects the true carry.
- Undefined: FIX is entered only on carry, as described in Behaviour.

Test Plan:
- Reset -> o_pc=16'hFFFC, o_ea=0, o_busy=0, o_idx_done=0. Apply pc_inc for 4 cycles -> o_pc=16'h0000 (wrap).
- ldlo with i_data=8'h34, then ldhi with i_data=8'h12 -> o_ea=16'h1234. pc_out=0 -> o_addr=16'h1234. pc_out=1 -> o_addr=o_pc.
- EA=16'h12F0, idx_start, index=8'h20, zpg=0:
  - Without ADDR_UNIT_ALWAYS_FIX_EN: o_busy high 2 cycles, o_idx_done at cycle+3, o_ea=16'h1310, o_page_cross=1.
  - With ADDR_UNIT_ALWAYS_FIX_EN: same timing and result.
- EA=16'h1210, index=8'h05, zpg=0:
  - Without ADDR_UNIT_ALWAYS_FIX_EN: o_idx_done at cycle+2, o_ea=16'h1215, o_page_cross=0.
  - With ADDR_UNIT_ALWAYS_FIX_EN: o_idx_done at cycle+3, same o_ea.
- EA=16'h00F0, index=8'h20, zpg=1 -> o_ea=16'h0010, o_page_cross=0, done at cycle+2. Also: EA=16'hFFF0, index=8'h20, zpg=0 -> o_ea=16'h0010.
- Concurrency and abort:
  - i_pc_load=1 (i_pc_val=16'h8000) and pc_inc=1 in the same cycle as a FIX -> o_pc=16'h8000, EA fix completes.
  - ldlo during ADD is ignored.
  - i_rst_n=0 during FIX -> immediate reset values, o_idx_done never pulses.

Source files
------------

// File: rtl/addr_unit.sv
// addr_unit: PC/EA address datapath with indexed EA add, page-cross fix-up and zero-page wrap.
// Optional: define ADDR_UNIT_ALWAYS_FIX_EN to route every non-zero-page index add through FIX.
module addr_unit #(
  parameter logic [15:0] RESET_PC = 16'hFFFC
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_ctrl,
  input  logic [7:0]  i_data,
  input  logic        i_pc_load,
  input  logic [15:0] i_pc_val,
  input  logic        i_idx_start,
  input  logic [7:0]  i_index_val,
  input  logic        i_zpg,
  output logic [15:0] o_addr,
  output logic [15:0] o_pc,
  output logic [15:0] o_ea,
  output logic        o_busy,
  output logic        o_idx_done,
  output logic        o_page_cross
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d, ea_q, ea_d;
  logic [7:0]  idx_q, idx_d;
  logic        zpg_q, zpg_d, cross_q, cross_d, done_q, done_d;
  logic [8:0]  sum;
  assign sum = {1'b0, ea_q[7:0]} + {1'b0, idx_q};
  // PC advances every cycle regardless of index activity; a jump load beats increment
  assign pc_d = i_pc_load ? i_pc_val : (i_ctrl[2] ? pc_q + 16'd1 : pc_q);
  // Index sequencer and EA byte loads; cross_q doubles as the carry consumed by FIX
  always_comb begin
    state_d = state_q;
    ea_d    = ea_q;
    idx_d   = idx_q;
    zpg_d   = zpg_q;
    cross_d = cross_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_idx_start) begin
          idx_d   = i_index_val;
          zpg_d   = i_zpg;
          state_d = ADD;
        end else begin
          ea_d[7:0]  = i_ctrl[1] ? i_data : ea_q[7:0];
          ea_d[15:8] = i_ctrl[0] ? i_data : ea_q[15:8];
        end
      end
      ADD: begin
        ea_d[7:0] = sum[7:0];
        if (zpg_q) begin
          ea_d[15:8] = 8'h00;
          cross_d    = 1'b0;
          state_d    = IDLE;
          done_d     = 1'b1;
        end else begin
          cross_d = sum[8];
`ifdef ADDR_UNIT_ALWAYS_FIX_EN
          state_d = FIX;
`else
          state_d = sum[8] ? FIX : IDLE;
          done_d  = ~sum[8];
`endif
        end
      end
      FIX: begin
        ea_d[15:8] = ea_q[15:8] + {7'b0, cross_q};
        state_d    = IDLE;
        done_d     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // State registers with asynchronous reset that aborts any index operation
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ea_q    <= 16'h0000;
      idx_q   <= 8'h00;
      zpg_q   <= 1'b0;
      cross_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ea_q    <= ea_d;
      idx_q   <= idx_d;
      zpg_q   <= zpg_d;
      cross_q <= cross_d;
      done_q  <= done_d;
    end
  end
  assign o_addr       = i_ctrl[3] ? pc_q : ea_q;
  assign o_pc         = pc_q;
  assign o_ea         = ea_q;
  assign o_busy       = (state_q == ADD) || (state_q == FIX);
  assign o_idx_done   = done_q;
  assign o_page_cross = cross_q;
endmodule

// File: tb/tb_addr_unit.sv
// tb_addr_unit: directed self-checking bench for addr_unit.
module tb_addr_unit;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [3:0]  i_ctrl = 4'b0;
  logic [7:0]  i_data = 8'h00;
  logic        i_pc_load = 1'b0;
  logic [15:0] i_pc_val = 16'h0000;
  logic        i_idx_start = 1'b0;
  logic [7:0]  i_index_val = 8'h00;
  logic        i_zpg = 1'b0;
  logic [15:0] o_addr, o_pc, o_ea;
  logic        o_busy, o_idx_done, o_page_cross;
  int n_checks = 0;
  int n_errors = 0;
  addr_unit dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ctrl(i_ctrl), .i_data(i_data),
    .i_pc_load(i_pc_load), .i_pc_val(i_pc_val), .i_idx_start(i_idx_start),
    .i_index_val(i_index_val), .i_zpg(i_zpg), .o_addr(o_addr), .o_pc(o_pc),
    .o_ea(o_ea), .o_busy(o_busy), .o_idx_done(o_idx_done), .o_page_cross(o_page_cross)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic load_ea(input logic [15:0] v);
    i_ctrl = 4'b0010; i_data = v[7:0];
    tick();
    i_ctrl = 4'b0001; i_data = v[15:8];
    tick();
    i_ctrl = 4'b0000;
    check("ea_load", o_ea, v);
  endtask
  // Start in cycle c; ADD in c+1 (poke ignored ldlo/idx_start), done in c+lat.
  task automatic run_idx(input string tag, input logic [15:0] ea0, input logic [7:0] idx,
                         input logic zpg, input logic [15:0] exp_ea, input logic exp_pc, input int lat);
    load_ea(ea0);
    i_idx_start = 1'b1; i_index_val = idx; i_zpg = zpg;
    tick();
    check({tag, "_busy_add"}, {15'b0, o_busy}, 16'd1);
    check({tag, "_done_add"}, {15'b0, o_idx_done}, 16'd0);
    i_idx_start = 1'b1; i_index_val = 8'hFF; i_zpg = ~zpg;
    i_ctrl = 4'b0010; i_data = 8'hAA;
    tick();
    i_idx_start = 1'b0; i_ctrl = 4'b0000;
    if (lat == 3) begin
      check({tag, "_busy_fix"}, {15'b0, o_busy}, 16'd1);
      check({tag, "_done_fix"}, {15'b0, o_idx_done}, 16'd0);
      i_pc_load = 1'b1; i_pc_val = 16'h8000; i_ctrl = 4'b0100;
      tick();
      i_pc_load = 1'b0; i_ctrl = 4'b0000;
      check({tag, "_pc_load"}, o_pc, 16'h8000);
    end
    check({tag, "_done"}, {15'b0, o_idx_done}, 16'd1);
    check({tag, "_busy_end"}, {15'b0, o_busy}, 16'd0);
    check({tag, "_ea"}, o_ea, exp_ea);
    check({tag, "_pcross"}, {15'b0, o_page_cross}, {15'b0, exp_pc});
    tick();
    check({tag, "_done_clr"}, {15'b0, o_idx_done}, 16'd0);
    check({tag, "_pcross_hold"}, {15'b0, o_page_cross}, {15'b0, exp_pc});
  endtask
  initial begin
    int nofix_lat;
`ifdef ADDR_UNIT_ALWAYS_FIX_EN
    nofix_lat = 3;
`else
    nofix_lat = 2;
`endif
    #12;
    check("rst_pc", o_pc, 16'hFFFC);
    check("rst_ea", o_ea, 16'h0000);
    check("rst_addr", o_addr, 16'h0000);
    check("rst_busy", {15'b0, o_busy}, 16'd0);
    check("rst_done", {15'b0, o_idx_done}, 16'd0);
    check("rst_pcross", {15'b0, o_page_cross}, 16'd0);
    tick();
    i_rst_n = 1'b1;
    i_ctrl = 4'b0100;
    repeat (3) tick();
    check("pc_inc3", o_pc, 16'hFFFF);
    tick();
    i_ctrl = 4'b0000;
    check("pc_wrap", o_pc, 16'h0000);
    load_ea(16'h1234);
    check("addr_ea", o_addr, 16'h1234);
    i_ctrl = 4'b1000;
    #1;
    check("addr_pc", o_addr, 16'h0000);
    i_ctrl = 4'b0011; i_data = 8'h5A;
    tick();
    i_ctrl = 4'b0000;
    check("ea_both", o_ea, 16'h5A5A);
    run_idx("cross", 16'h12F0, 8'h20, 1'b0, 16'h1310, 1'b1, 3);
    run_idx("nocross", 16'h1210, 8'h05, 1'b0, 16'h1215, 1'b0, nofix_lat);
    run_idx("zpg", 16'h00F0, 8'h20, 1'b1, 16'h0010, 1'b0, 2);
    run_idx("zpg_hi", 16'h12F0, 8'h20, 1'b1, 16'h0010, 1'b0, 2);
    run_idx("wrap", 16'hFFF0, 8'h20, 1'b0, 16'h0010, 1'b1, 3);
    load_ea(16'h12F0);
    i_idx_start = 1'b1; i_index_val = 8'h20; i_zpg = 1'b0;
    tick();
    i_idx_start = 1'b0;
    tick();
    check("abort_in_fix", {15'b0, o_busy}, 16'd1);
    i_rst_n = 1'b0;
    #1;
    check("abort_pc", o_pc, 16'hFFFC);
    check("abort_ea", o_ea, 16'h0000);
    check("abort_busy", {15'b0, o_busy}, 16'd0);
    check("abort_pcross", {15'b0, o_page_cross}, 16'd0);
    repeat (3) begin
      tick();
      check("abort_done", {15'b0, o_idx_done}, 16'd0);
    end
    i_rst_n = 1'b1;
    tick();
    check("abort_idle_done", {15'b0, o_idx_done}, 16'd0);
    check("abort_idle_ea", o_ea, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
